ram_fifo_ctrl: RTL

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl_pkg.sv | 15 +
 rtl/ram_fifo_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared definitions for the RAM-backed FIFO controller: default widths and
// the 2-bit sequencer state encoding.
package ram_fifo_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WRITE   = 2'b01,
        ST_READ    = 2'b10,
        ST_CAPTURE = 2'b11
    } fifo_state_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that stores words in an external single-port RAM and keeps
// the head word in an output register in front of it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus released; accept a push or start refilling rd_data
// WRITE    | one-cycle RAM write of the latched word at wptr
// READ     | RAM read at rptr, data settling on the bus
// CAPTURE  | RAM read held; rd_data loaded from the bus at exit
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_cs,
    output logic                  ram_w_r1,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    fifo_state_t           state;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   ram_count;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  drive_en;
    logic                  need_fill;
    logic                  can_push;

    // Refilling an empty output register always wins over a new push.
    assign need_fill = !rd_valid && (ram_count != '0);
    assign can_push  = (state == ST_IDLE) && (ram_count < DEPTH_CNT) && !need_fill;
    assign wr_ready  = rst_n && can_push;
    assign occupancy = ram_count + (ADDR_WIDTH + 1)'(rd_valid);
    assign ram_data  = drive_en ? wdata_q : 'z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wptr        <= '0;
            rptr        <= '0;
            ram_count   <= '0;
            wdata_q     <= '0;
            drive_en    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            ram_address <= '0;
            ram_cs      <= 1'b0;
            ram_w_r1    <= 1'b0;
            ram_oe      <= 1'b0;
        end else begin
            if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (need_fill) begin
                        state       <= ST_READ;
                        ram_cs      <= 1'b1;
                        ram_w_r1    <= 1'b0;
                        ram_oe      <= 1'b1;
                        ram_address <= rptr;
                    end else if (wr_valid && can_push) begin
                        state       <= ST_WRITE;
                        wdata_q     <= wr_data;
                        drive_en    <= 1'b1;
                        ram_cs      <= 1'b1;
                        ram_w_r1    <= 1'b1;
                        ram_oe      <= 1'b0;
                        ram_address <= wptr;
                    end
                end
                ST_WRITE: begin
                    state     <= ST_IDLE;
                    wptr      <= wptr + ADDR_WIDTH'(1);
                    ram_count <= ram_count + (ADDR_WIDTH + 1)'(1);
                    drive_en  <= 1'b0;
                    ram_cs    <= 1'b0;
                    ram_w_r1  <= 1'b0;
                end
                ST_READ: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state     <= ST_IDLE;
                    rd_data   <= ram_data;
                    rd_valid  <= 1'b1;
                    rptr      <= rptr + ADDR_WIDTH'(1);
                    ram_count <= ram_count - (ADDR_WIDTH + 1)'(1);
                    ram_cs    <= 1'b0;
                    ram_oe    <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
